// File: rtl/icache_if.sv
// icache_if: IF-side fetch handshake and MC byte-read port of the instruction cache
interface icache_if;
  logic        ICache_in;
  logic [17:0] ICacheAddr_in;
  logic        instE_out;
  logic [31:0] inst_out;
  logic        mcReq_out;
  logic [17:0] mcAddr_out;
  logic        mcValid_in;
  logic [7:0]  mcData_in;
  modport slave (
    input  ICache_in, ICacheAddr_in, mcValid_in, mcData_in,
    output instE_out, inst_out, mcReq_out, mcAddr_out
  );
  modport master (
    output ICache_in, ICacheAddr_in, mcValid_in, mcData_in,
    input  instE_out, inst_out, mcReq_out, mcAddr_out
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache, byte-wise refill from the MC
module icache #(
  parameter int INDEX_BITS = 7
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  icache_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS;
  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;
  state_t state_q, state_d;
  logic [17:0] base_q, base_d, mc_addr_q, mc_addr_d;
  logic [1:0] k_q, k_d;
  logic [31:0] buf_q, buf_d, inst_q, inst_d;
  logic inst_e_q, inst_e_d, mc_req_q, mc_req_d;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0] data_q [LINES];
  logic [INDEX_BITS-1:0] req_idx, base_idx;
  logic [TAG_W-1:0] req_tag, base_tag;
  logic hit, abort, accept, fill_we;
  assign req_idx  = bus.ICacheAddr_in[INDEX_BITS+1:2];
  assign req_tag  = bus.ICacheAddr_in[17:INDEX_BITS+2];
  assign base_idx = base_q[INDEX_BITS+1:2];
  assign base_tag = base_q[17:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && tag_q[req_idx] == req_tag;
  // abort wins over a byte arriving on the same edge
  assign abort    = !bus.ICache_in || bus.ICacheAddr_in != base_q;
  assign accept   = state_q == MISS && mc_req_q && bus.mcValid_in && !abort;
  assign fill_we  = accept && k_q == 2'd3;
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    k_d       = k_q;
    buf_d     = buf_q;
    inst_d    = inst_q;
    inst_e_d  = 1'b0;
    mc_req_d  = mc_req_q;
    mc_addr_d = mc_addr_q;
    case (state_q)
      IDLE: if (bus.ICache_in) begin
        if (hit) begin
          inst_e_d = 1'b1;
          inst_d   = data_q[req_idx];
          state_d  = RESP;
        end else begin
          base_d    = bus.ICacheAddr_in;
          k_d       = 2'd0;
          mc_req_d  = 1'b1;
          mc_addr_d = bus.ICacheAddr_in;
          state_d   = MISS;
        end
      end
      MISS: if (abort) begin
        mc_req_d = 1'b0;
        state_d  = IDLE;
      end else if (accept) begin
        buf_d[{k_q, 3'b000} +: 8] = bus.mcData_in;
        k_d       = k_q + 2'd1;
        mc_addr_d = base_q + 18'(k_q) + 18'd1;
        if (k_q == 2'd3) begin
          mc_req_d = 1'b0;
          inst_e_d = 1'b1;
          inst_d   = buf_d;
          state_d  = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      base_q    <= '0;
      k_q       <= '0;
      buf_q     <= '0;
      inst_q    <= '0;
      inst_e_q  <= 1'b0;
      mc_req_q  <= 1'b0;
      mc_addr_q <= '0;
      valid_q   <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      base_q    <= base_d;
      k_q       <= k_d;
      buf_q     <= buf_d;
      inst_q    <= inst_d;
      inst_e_q  <= inst_e_d;
      mc_req_q  <= mc_req_d;
      mc_addr_q <= mc_addr_d;
      if (fill_we) valid_q[base_idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_we) begin
      tag_q[base_idx]  <= base_tag;
      data_q[base_idx] <= buf_d;
    end
  end
  assign bus.instE_out  = inst_e_q;
  assign bus.inst_out   = inst_q;
  assign bus.mcReq_out  = mc_req_q;
  assign bus.mcAddr_out = mc_addr_q;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for the instruction cache
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int checks = 0;
  int errors = 0;
  icache_if bus();
  icache #(.INDEX_BITS(7)) dut (.clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic mc_byte(input logic [7:0] d);
    step();
    bus.mcValid_in = 1'b1;
    bus.mcData_in  = d;
    step();
    bus.mcValid_in = 1'b0;
  endtask
  task automatic miss_fill(input logic [17:0] a, input logic [31:0] w);
    bus.ICache_in = 1'b1;
    bus.ICacheAddr_in = a;
    step();
    chk("miss_req", 32'(bus.mcReq_out), 32'd1);
    chk("miss_addr0", 32'(bus.mcAddr_out), 32'(a));
    for (int i = 0; i < 4; i++) begin
      mc_byte(w[8*i +: 8]);
      if (i < 3) begin
        chk("miss_addr_step", 32'(bus.mcAddr_out), 32'(a) + 32'(i) + 32'd1);
        chk("miss_no_resp", 32'(bus.instE_out), 32'd0);
      end
    end
    chk("fill_inste", 32'(bus.instE_out), 32'd1);
    chk("fill_inst", bus.inst_out, w);
    chk("fill_req_drop", 32'(bus.mcReq_out), 32'd0);
    bus.ICache_in = 1'b0;
    step();
    chk("fill_inste_low", 32'(bus.instE_out), 32'd0);
    chk("fill_inst_hold", bus.inst_out, w);
  endtask
  task automatic hit(input logic [17:0] a, input logic [31:0] w);
    bus.ICache_in = 1'b1;
    bus.ICacheAddr_in = a;
    step();
    chk("hit_inste", 32'(bus.instE_out), 32'd1);
    chk("hit_inst", bus.inst_out, w);
    chk("hit_no_req", 32'(bus.mcReq_out), 32'd0);
    bus.ICache_in = 1'b0;
    step();
    chk("hit_inste_low", 32'(bus.instE_out), 32'd0);
  endtask
  initial begin
    bus.ICache_in = 1'b0;
    bus.ICacheAddr_in = '0;
    bus.mcValid_in = 1'b0;
    bus.mcData_in = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_inste", 32'(bus.instE_out), 32'd0);
    chk("rst_inst", bus.inst_out, 32'd0);
    chk("rst_req", 32'(bus.mcReq_out), 32'd0);
    chk("rst_addr", 32'(bus.mcAddr_out), 32'd0);
    // cold miss then hit
    miss_fill(18'h00100, 32'h00100513);
    hit(18'h00100, 32'h00100513);
    // conflict eviction on index 0, plus evicting 0x100's line
    miss_fill(18'h00000, 32'hdeadbeef);
    hit(18'h00000, 32'hdeadbeef);
    miss_fill(18'h00200, 32'h11223344);
    miss_fill(18'h00000, 32'hdeadbeef);
    miss_fill(18'h00200, 32'h11223344);
    miss_fill(18'h04100, 32'hcafef00d);
    // held request on a hitting address pulses 1,0,1
    bus.ICache_in = 1'b1;
    bus.ICacheAddr_in = 18'h04100;
    step();
    chk("held_p1", 32'(bus.instE_out), 32'd1);
    step();
    chk("held_p2", 32'(bus.instE_out), 32'd0);
    step();
    chk("held_p3", 32'(bus.instE_out), 32'd1);
    bus.ICache_in = 1'b0;
    step();
    chk("held_p4", 32'(bus.instE_out), 32'd0);
    // abort after two bytes
    bus.ICache_in = 1'b1;
    bus.ICacheAddr_in = 18'h00300;
    step();
    mc_byte(8'haa);
    mc_byte(8'hbb);
    chk("abort_addr_before", 32'(bus.mcAddr_out), 32'h302);
    bus.ICache_in = 1'b0;
    step();
    chk("abort_req_drop", 32'(bus.mcReq_out), 32'd0);
    chk("abort_no_resp", 32'(bus.instE_out), 32'd0);
    step();
    chk("abort_no_resp2", 32'(bus.instE_out), 32'd0);
    miss_fill(18'h00300, 32'h0badf00d);
    // address change mid-miss, coinciding with a byte
    bus.ICache_in = 1'b1;
    bus.ICacheAddr_in = 18'h00100;
    step();
    chk("chg_miss", 32'(bus.mcReq_out), 32'd1);
    mc_byte(8'h13);
    chk("chg_addr1", 32'(bus.mcAddr_out), 32'h101);
    bus.ICacheAddr_in = 18'h00204;
    bus.mcValid_in = 1'b1;
    bus.mcData_in = 8'h05;
    step();
    bus.mcValid_in = 1'b0;
    chk("chg_req_drop", 32'(bus.mcReq_out), 32'd0);
    chk("chg_addr_frozen", 32'(bus.mcAddr_out), 32'h101);
    chk("chg_no_resp", 32'(bus.instE_out), 32'd0);
    miss_fill(18'h00204, 32'h00a00093);
    // rdy stall mid-miss with bytes offered
    bus.ICache_in = 1'b1;
    bus.ICacheAddr_in = 18'h00500;
    step();
    mc_byte(8'h78);
    chk("stall_addr_pre", 32'(bus.mcAddr_out), 32'h501);
    rdy = 1'b0;
    bus.mcValid_in = 1'b1;
    bus.mcData_in = 8'hff;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", 32'(bus.mcAddr_out), 32'h501);
      chk("stall_req", 32'(bus.mcReq_out), 32'd1);
    end
    rdy = 1'b1;
    bus.mcValid_in = 1'b0;
    mc_byte(8'h56);
    chk("stall_addr_resume", 32'(bus.mcAddr_out), 32'h502);
    mc_byte(8'h34);
    mc_byte(8'h12);
    chk("stall_inste", 32'(bus.instE_out), 32'd1);
    chk("stall_inst", bus.inst_out, 32'h12345678);
    bus.ICache_in = 1'b0;
    step();
    hit(18'h00500, 32'h12345678);
    // reset mid-miss
    bus.ICache_in = 1'b1;
    bus.ICacheAddr_in = 18'h00600;
    step();
    mc_byte(8'h99);
    rst = 1'b1;
    step();
    chk("rstm_req", 32'(bus.mcReq_out), 32'd0);
    chk("rstm_addr", 32'(bus.mcAddr_out), 32'd0);
    chk("rstm_inste", 32'(bus.instE_out), 32'd0);
    chk("rstm_inst", bus.inst_out, 32'd0);
    rst = 1'b0;
    bus.ICache_in = 1'b0;
    step();
    bus.ICache_in = 1'b1;
    bus.ICacheAddr_in = 18'h00500;
    step();
    chk("rstm_now_miss", 32'(bus.mcReq_out), 32'd1);
    chk("rstm_no_hit", 32'(bus.instE_out), 32'd0);
    bus.ICache_in = 1'b0;
    step();
    chk("rstm_abort", 32'(bus.mcReq_out), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
